// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: combinational hit path, 4-word block
// refill over a request/ready handshake, saturating miss counter.
module icache_dm #(
  parameter int LINES = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_req,
  input  logic [31:0]      cpu_addr,
  output logic [31:0]      cpu_rdata,
  output logic             cpu_stall,
  output logic             mem_read,
  output logic [27:0]      mem_addr,
  input  logic [127:0]     mem_rdata,
  input  logic             mem_ready,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int IW = $clog2(LINES);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t            state;
  logic [LINES-1:0]  valid;
  logic [27-IW:0]    tag_mem  [LINES];
  logic [127:0]      data_mem [LINES];

  logic [IW-1:0]     idx;
  logic [27-IW:0]    tag;
  logic [1:0]        off;
  logic              hit;
  logic [127:0]      line_data;
  logic [31:0]       word;
  logic              addr_unused;

  assign idx         = cpu_addr[3+IW:4];
  assign tag         = cpu_addr[31:4+IW];
  assign off         = cpu_addr[3:2];
  assign addr_unused = &{1'b0, cpu_addr[1:0]};

  assign hit       = valid[idx] && (tag_mem[idx] == tag);
  assign line_data = data_mem[idx];

  always_comb begin
    word = '0;
    case (off)
      2'd0: word = line_data[31:0];
      2'd1: word = line_data[63:32];
      2'd2: word = line_data[95:64];
      2'd3: word = line_data[127:96];
      default: word = '0;
    endcase
  end

  // FETCH always stalls, even if the core has dropped its request.
  assign cpu_stall = (state == FETCH) || (cpu_req && !hit);
  assign cpu_rdata = (state == IDLE && cpu_req && hit) ? word : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      valid    <= '0;
      mem_read <= 1'b0;
      mem_addr <= '0;
      miss_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req && !hit) begin
            state    <= FETCH;
            mem_read <= 1'b1;
            mem_addr <= cpu_addr[31:4];
            if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
          end
        end
        FETCH: begin
          if (mem_ready) begin
            state                 <= IDLE;
            mem_read              <= 1'b0;
            valid[mem_addr[IW-1:0]] <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data arrays are not reset; the valid bits gate them.
  always_ff @(posedge clk) begin
    if (state == FETCH && mem_ready) begin
      tag_mem[mem_addr[IW-1:0]]  <= mem_addr[27:IW];
      data_mem[mem_addr[IW-1:0]] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: main instance with default parameters and a
// second instance with a 2-bit miss counter for saturation.
module tb_icache_dm;

  logic         clk;
  logic         rst_n;
  logic         cpu_req;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_rdata;
  logic         cpu_stall;
  logic         mem_read;
  logic [27:0]  mem_addr;
  logic [127:0] mem_rdata;
  logic         mem_ready;
  logic [15:0]  miss_cnt;

  logic         cpu_req2;
  logic [31:0]  cpu_addr2;
  logic [31:0]  cpu_rdata2;
  logic         cpu_stall2;
  logic         mem_read2;
  logic [27:0]  mem_addr2;
  logic [127:0] mem_rdata2;
  logic         mem_ready2;
  logic [1:0]   miss_cnt2;

  int unsigned vectors;
  int unsigned miscompares;

  localparam logic [127:0] BLK_A = {32'h01095022, 32'h01084020, 32'h8C090001, 32'h8C080000};
  localparam logic [127:0] BLK_B = {32'hB0000003, 32'hB0000002, 32'hB0000001, 32'hB0000000};
  localparam logic [127:0] BLK_C = {32'hC0000003, 32'hC0000002, 32'hC0000001, 32'hC0000000};

  icache_dm #(.LINES(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .mem_read(mem_read),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .miss_cnt(miss_cnt)
  );

  icache_dm #(.LINES(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req2), .cpu_addr(cpu_addr2),
    .cpu_rdata(cpu_rdata2), .cpu_stall(cpu_stall2), .mem_read(mem_read2),
    .mem_addr(mem_addr2), .mem_rdata(mem_rdata2), .mem_ready(mem_ready2),
    .miss_cnt(miss_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b0; cpu_req = 1'b0; cpu_addr = '0; mem_rdata = '0; mem_ready = 1'b0;
    cpu_req2 = 1'b0; cpu_addr2 = '0; mem_rdata2 = '0; mem_ready2 = 1'b0;

    // Reset state
    step(); #1;
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_miss_cnt", 32'(miss_cnt), 32'd0);
    check("rst_stall_noreq", 32'(cpu_stall), 32'd0);
    cpu_req = 1'b1; #1;
    check("rst_stall_req", 32'(cpu_stall), 32'd1);
    check("rst_rdata", cpu_rdata, 32'd0);
    cpu_req = 1'b0;
    step(); rst_n = 1'b1;

    // Cold miss: cycle 0
    step(); cpu_req = 1'b1; cpu_addr = 32'h0; #1;
    check("cold_c0_stall", 32'(cpu_stall), 32'd1);
    check("cold_c0_mem_read", 32'(mem_read), 32'd0);
    step(); #1; // cycle 1
    check("cold_c1_mem_read", 32'(mem_read), 32'd1);
    check("cold_c1_mem_addr", 32'(mem_addr), 32'h0);
    check("cold_c1_stall", 32'(cpu_stall), 32'd1);
    check("cold_c1_miss_cnt", 32'(miss_cnt), 32'd1);
    step(); #1; // cycle 2
    check("cold_c2_stall", 32'(cpu_stall), 32'd1);
    step(); mem_ready = 1'b1; mem_rdata = BLK_A; #1; // cycle 3
    check("cold_c3_stall", 32'(cpu_stall), 32'd1);
    check("cold_c3_mem_read", 32'(mem_read), 32'd1);
    step(); mem_ready = 1'b0; mem_rdata = '0; #1; // cycle 4
    check("cold_c4_stall", 32'(cpu_stall), 32'd0);
    check("cold_c4_rdata", cpu_rdata, 32'h8C080000);
    check("cold_c4_mem_read", 32'(mem_read), 32'd0);
    check("cold_c4_miss_cnt", 32'(miss_cnt), 32'd1);

    // Spatial hits
    step(); cpu_addr = 32'h4; #1;
    check("hit4_stall", 32'(cpu_stall), 32'd0);
    check("hit4_rdata", cpu_rdata, 32'h8C090001);
    step(); cpu_addr = 32'h8; #1;
    check("hit8_stall", 32'(cpu_stall), 32'd0);
    check("hit8_rdata", cpu_rdata, 32'h01084020);
    check("hit8_mem_read", 32'(mem_read), 32'd0);
    step(); cpu_addr = 32'hC; #1;
    check("hitC_stall", 32'(cpu_stall), 32'd0);
    check("hitC_rdata", cpu_rdata, 32'h01095022);
    check("hitC_mem_read", 32'(mem_read), 32'd0);

    // Conflict: 0x80 maps to line 0 with a new tag
    step(); cpu_addr = 32'h80; #1;
    check("conf80_stall", 32'(cpu_stall), 32'd1);
    step(); mem_ready = 1'b1; mem_rdata = BLK_B; #1;
    check("conf80_mem_addr", 32'(mem_addr), 32'h8);
    check("conf80_mem_read", 32'(mem_read), 32'd1);
    step(); mem_ready = 1'b0; #1;
    check("conf80_hit_rdata", cpu_rdata, 32'hB0000000);
    check("conf80_hit_stall", 32'(cpu_stall), 32'd0);
    step(); cpu_addr = 32'h0; #1;
    check("conf0_stall", 32'(cpu_stall), 32'd1);
    step(); mem_ready = 1'b1; mem_rdata = BLK_A; #1;
    check("conf0_mem_addr", 32'(mem_addr), 32'h0);
    check("conf0_miss_cnt", 32'(miss_cnt), 32'd3);
    step(); mem_ready = 1'b0; #1;
    check("conf0_hit_rdata", cpu_rdata, 32'h8C080000);

    // Address change during fetch
    step(); cpu_addr = 32'h10; #1;
    check("chg_miss_stall", 32'(cpu_stall), 32'd1);
    step(); cpu_addr = 32'h0; #1;
    check("chg_mem_addr", 32'(mem_addr), 32'h1);
    check("chg_fetch_stall", 32'(cpu_stall), 32'd1);
    check("chg_fetch_rdata", cpu_rdata, 32'd0);
    step(); mem_ready = 1'b1; mem_rdata = BLK_C; #1;
    check("chg_mem_addr_held", 32'(mem_addr), 32'h1);
    step(); mem_ready = 1'b0; #1;
    check("chg_hit0_stall", 32'(cpu_stall), 32'd0);
    check("chg_hit0_rdata", cpu_rdata, 32'h8C080000);
    check("chg_hit0_mem_read", 32'(mem_read), 32'd0);
    check("chg_miss_cnt", 32'(miss_cnt), 32'd4);
    step(); cpu_addr = 32'h14; #1;
    check("chg_line1_stall", 32'(cpu_stall), 32'd0);
    check("chg_line1_rdata", cpu_rdata, 32'hC0000001);

    // Reset mid-fetch
    step(); cpu_addr = 32'h20; #1;
    check("rmf_miss_stall", 32'(cpu_stall), 32'd1);
    step(); #1;
    check("rmf_mem_read", 32'(mem_read), 32'd1);
    #1 rst_n = 1'b0; #1;
    check("rmf_abort_mem_read", 32'(mem_read), 32'd0);
    check("rmf_abort_miss_cnt", 32'(miss_cnt), 32'd0);
    check("rmf_abort_mem_addr", 32'(mem_addr), 32'd0);
    step(); rst_n = 1'b1; cpu_addr = 32'h0; #1;
    check("rmf_0_misses", 32'(cpu_stall), 32'd1);
    check("rmf_cnt_before", 32'(miss_cnt), 32'd0);
    step(); mem_ready = 1'b1; mem_rdata = BLK_A; #1;
    check("rmf_cnt_after", 32'(miss_cnt), 32'd1);
    check("rmf_refetch_read", 32'(mem_read), 32'd1);
    step(); mem_ready = 1'b0; cpu_req = 1'b0; #1;
    check("rmf_idle_rdata", cpu_rdata, 32'd0);

    // Saturation on the 2-bit counter: five conflict misses on line 0
    for (int i = 0; i < 5; i++) begin
      step(); cpu_req2 = 1'b1; cpu_addr2 = 32'(i) * 32'h80; mem_ready2 = 1'b0; #1;
      check("sat_miss_stall", 32'(cpu_stall2), 32'd1);
      step(); mem_ready2 = 1'b1; mem_rdata2 = BLK_B; #1;
      check("sat_mem_read", 32'(mem_read2), 32'd1);
      step(); mem_ready2 = 1'b0; #1;
      check("sat_hit_stall", 32'(cpu_stall2), 32'd0);
      check("sat_miss_cnt", 32'(miss_cnt2), (i + 1 < 3) ? 32'(i + 1) : 32'd3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
